// File: rtl/apb_slave_pkg.sv
// Shared types and address-decode helpers for the APB word-register completer.
package apb_slave_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

    // Addresses are widened to 64 bits so one helper serves any PADDR width.
    function automatic logic [7:0] addr_to_idx(input logic [63:0] addr, input int num_regs);
        logic [63:0] mask;
        mask = 64'(num_regs - 1);
        return 8'((addr >> 2) & mask);
    endfunction

    function automatic logic addr_err(input logic [63:0] addr, input logic write,
                                      input int num_regs);
        logic misaligned;
        logic out_of_range;
        logic read_only;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = (addr >= (64'(num_regs) << 2));
        read_only    = write && (addr_to_idx(addr, num_regs) == 8'd0);
        return misaligned || out_of_range || read_only;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between bridge and register file; PSTRB exists only with APB_SLAVE_PSTRB_EN.
interface apb_slave_regfile_if
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Handshake: a transfer completes on the edge where PSEL, PENABLE and PREADY are all 1;
    // PSLVERR and PRDATA are meaningful only in that cycle, and the master holds
    // PADDR/PWRITE/PWDATA/PSTRB stable from SETUP through completion.
    logic                    PSEL;
    logic                    PENABLE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
    logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;
    state_e                  dbg_state;

    modport master (
`ifdef APB_SLAVE_PSTRB_EN
        output PSTRB,
`endif
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR, dbg_state
    );

    modport slave (
`ifdef APB_SLAVE_PSTRB_EN
        input  PSTRB,
`endif
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR, dbg_state
    );

endinterface

// File: rtl/apb_slave_regbank.sv
// Word register storage with byte-lane write enables; register 0 reads as a fixed ID.
module apb_slave_regbank #(
    parameter int              NUM_REGS   = 8,
    parameter int              DATA_WIDTH = 32,
    parameter logic [31:0]     ID_VALUE   = 32'hA9B0_0001,
    parameter int              IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_strb[b]) begin
                    regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
        // Slot 0 is never storage; its reads come from ID_VALUE.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data = (rd_idx == '0) ? ID_VALUE : regs_q[rd_idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: word register bank, fixed wait states, PSLVERR on decode errors.
// Optional byte strobes via APB_SLAVE_PSTRB_EN.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_slave_regfile_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    state_e                  state_d, state_q;
    logic [3:0]              cnt_d, cnt_q;
    logic [63:0]             addr_ext;
    logic [IDX_W-1:0]        idx;
    logic                    err;
    logic                    pready;
    logic                    wr_en;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign addr_ext = 64'(bus.PADDR);
    assign idx      = IDX_W'(addr_to_idx(addr_ext, NUM_REGS));
    assign err      = addr_err(addr_ext, bus.PWRITE, NUM_REGS);
    assign pready   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ST_ACCESS: begin
                // Losing PSEL before completion abandons the transfer.
                if (!bus.PSEL) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (bus.PENABLE) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef APB_SLAVE_PSTRB_EN
    assign wr_strb = bus.PSTRB;
`else
    assign wr_strb = '1;
`endif

    assign wr_en = pready && bus.PSEL && bus.PENABLE && bus.PWRITE && !err;

    apb_slave_regbank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_VALUE   (ID_VALUE),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (bus.PWDATA),
        .wr_strb (wr_strb),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    assign bus.PREADY    = pready;
    assign bus.PSLVERR   = pready && err;
    assign bus.PRDATA    = (pready && !err && !bus.PWRITE) ? rd_data : '0;
    assign bus.dbg_state = state_q;

endmodule
